// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for a registered-output FIFO: issues pops, absorbs the read latency
// and streams words through a 2-entry skid buffer. Define FIFO_DRAIN_LAST_EN for out_last burst framing.
module fifo_drain_ctrl #(
  parameter int WIDTH     = 64,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [15:0]      word_count,
  output logic             busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  if (BURST_LEN < 1) begin : g_bad_burst
    $error("fifo_drain_ctrl: BURST_LEN must be at least 1");
  end

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             pop;
  logic [2:0]       committed;

  assign out_valid = (occ != 2'd0);
  assign out_data  = slot0;
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // Words already owed to the buffer: held entries plus the read whose data lands this cycle.
  assign committed = {1'b0, occ} + {2'b00, inflight};
  assign fifo_ren  = reset && enable && !fifo_empty && (state != DRAIN) &&
                     (committed < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_next = ((occ != 2'd0) || inflight) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (enable)
          state_next = ACTIVE;
        else if ((occ == 2'd0) && !inflight)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // slot0 is always the head; a capture lands in the first slot left free after this cycle's pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      occ        <= 2'd0;
      inflight   <= 1'b0;
      slot0      <= '0;
      slot1      <= '0;
      word_count <= 16'd0;
    end else begin
      state    <= state_next;
      inflight <= fifo_ren;
      if (pop) word_count <= word_count + 16'd1;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0)
            slot0 <= fifo_dout;
          else
            slot1 <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= fifo_dout;
          end else begin
            slot0 <= slot1;
            slot1 <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_DRAIN_LAST_EN
  localparam int              BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [BEAT_W-1:0] beat;

  always_ff @(posedge clk) begin
    if (!reset)
      beat <= '0;
    else if (pop)
      beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_W'(1);
  end

  assign out_last = out_valid && (beat == LAST_BEAT);
`else
  assign out_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a queue-based FIFO plus a transaction-level model of the
// drain controller, driven by directed scenarios and a long randomized run.
module tb_fifo_drain_ctrl;

  localparam int WIDTH     = 64;
  localparam int BURST_LEN = 4;
  localparam int M_IDLE    = 0;
  localparam int M_ACTIVE  = 1;
  localparam int M_DRAIN   = 2;

  logic             clk        = 1'b0;
  logic             reset      = 1'b0;
  logic             enable     = 1'b0;
  logic             out_ready  = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout  = '0;
  logic             fifo_ren;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      word_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] pend[$];
  int   m_state    = M_IDLE;
  logic m_inflight = 1'b0;
  int   m_count    = 0;
  int   m_beat     = 0;
  logic checks_on  = 1'b0;
  int   ren_pulses = 0;
  int   valid_cycles = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.WIDTH(WIDTH), .BURST_LEN(BURST_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .fifo_dout  (fifo_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .word_count (word_count),
    .busy       (busy)
  );

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic rst);
    @(posedge clk);
    #1;
    enable    = en;
    out_ready = rdy;
    reset     = rst;
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    fq.push_back(w);
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // Reference model: pend holds every word taken from the FIFO and not yet delivered;
  // the newest one is not presentable until the cycle after its pop.
  initial begin
    int               occ_m;
    logic             e_valid;
    logic             e_pop;
    logic             e_ren;
    logic             e_last;
    logic [WIDTH-1:0] w;
    forever begin
      @(negedge clk);
      occ_m   = pend.size() - int'(m_inflight);
      e_valid = (occ_m > 0);
      e_pop   = e_valid && out_ready;
      e_ren   = reset && enable && !fifo_empty && (m_state != M_DRAIN) &&
                ((pend.size() - int'(e_pop)) < 2);
`ifdef FIFO_DRAIN_LAST_EN
      e_last  = e_valid && (m_beat == BURST_LEN - 1);
`else
      e_last  = 1'b0;
`endif
      if (checks_on) begin
        checkOutput("fifo_ren", WIDTH'(fifo_ren), WIDTH'(e_ren));
        checkOutput("out_valid", WIDTH'(out_valid), WIDTH'(e_valid));
        if (e_valid) checkOutput("out_data", out_data, pend[0]);
        checkOutput("busy", WIDTH'(busy), WIDTH'(m_state != M_IDLE));
        checkOutput("word_count", WIDTH'(word_count), WIDTH'(m_count[15:0]));
        checkOutput("out_last", WIDTH'(out_last), WIDTH'(e_last));
      end

      @(posedge clk);
      if (fifo_ren) ren_pulses++;
      if (out_valid) valid_cycles++;
      if (!reset) begin
        fq.delete();
        pend.delete();
        m_inflight  = 1'b0;
        m_state     = M_IDLE;
        m_count     = 0;
        m_beat      = 0;
        fifo_empty <= 1'b1;
      end else begin
        w = '0;
        if (fifo_ren && (fq.size() > 0)) begin
          w = fq.pop_front();
          fifo_dout <= w;
        end
        fifo_empty <= (fq.size() == 0);
        case (m_state)
          M_IDLE:   if (enable) m_state = M_ACTIVE;
          M_ACTIVE: if (!enable) m_state = ((occ_m > 0) || m_inflight) ? M_DRAIN : M_IDLE;
          default: begin
            if (enable) m_state = M_ACTIVE;
            else if ((occ_m == 0) && !m_inflight) m_state = M_IDLE;
          end
        endcase
        if (e_pop) begin
          void'(pend.pop_front());
          m_count++;
          m_beat = (m_beat == BURST_LEN - 1) ? 0 : m_beat + 1;
        end
        if (e_ren) pend.push_back(w);
        m_inflight = e_ren;
      end
    end
  end

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checks_on = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", WIDTH'(out_valid), '0);
    checkOutput("rst_word_count", WIDTH'(word_count), '0);
    checkOutput("rst_busy", WIDTH'(busy), '0);
    checkOutput("rst_fifo_ren", WIDTH'(fifo_ren), '0);
    checkOutput("rst_out_data", out_data, '0);

    // Single word
    applyStimulus(1'b0, 1'b1, 1'b1);
    pushWord(WIDTH'(8'hA5));
    ren_pulses = 0;
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("single_ren_pulses", WIDTH'(ren_pulses), WIDTH'(1));
    checkOutput("single_word_count", WIDTH'(word_count), WIDTH'(1));
    checkOutput("single_busy", WIDTH'(busy), '0);

    // Streaming
    resetDut();
    for (int i = 0; i < 16; i++) pushWord(WIDTH'(i));
    valid_cycles = 0;
    repeat (22) applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stream_word_count", WIDTH'(word_count), WIDTH'(16));
    checkOutput("stream_valid_cycles", WIDTH'(valid_cycles), WIDTH'(16));

    // Backpressure
    resetDut();
    for (int i = 0; i < 20; i++) pushWord(WIDTH'(100 + i));
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b1);
    ren_pulses = 0;
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("bp_ren_during_hold", WIDTH'(ren_pulses <= 1), WIDTH'(1));
    checkOutput("bp_buffered", WIDTH'(20 - fq.size() - int'(word_count)), WIDTH'(2));
    checkOutput("bp_valid_held", WIDTH'(out_valid), WIDTH'(1));
    repeat (30) applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp_word_count", WIDTH'(word_count), WIDTH'(20));
    checkOutput("bp_fifo_left", WIDTH'(fq.size()), '0);

    // Drain on disable
    resetDut();
    for (int i = 0; i < 8; i++) pushWord(WIDTH'(200 + i));
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("drain_busy", WIDTH'(busy), WIDTH'(1));
    checkOutput("drain_valid", WIDTH'(out_valid), WIDTH'(1));
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("drain_idle", WIDTH'(busy), '0);
    checkOutput("drain_word_count", WIDTH'(word_count), WIDTH'(2));
    checkOutput("drain_fifo_left", WIDTH'(fq.size()), WIDTH'(6));

    // Reset mid-burst with the buffer full
    resetDut();
    for (int i = 0; i < 10; i++) pushWord(WIDTH'(300 + i));
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", WIDTH'(out_valid), '0);
    checkOutput("midrst_word_count", WIDTH'(word_count), '0);
    checkOutput("midrst_last", WIDTH'(out_last), '0);
    checkOutput("midrst_busy", WIDTH'(busy), '0);
    checkOutput("midrst_data", out_data, '0);

    // Empty FIFO
    resetDut();
    ren_pulses   = 0;
    valid_cycles = 0;
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("empty_ren_pulses", WIDTH'(ren_pulses), '0);
    checkOutput("empty_valid_cycles", WIDTH'(valid_cycles), '0);

    // Randomized traffic with occasional resets
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 600) != 0);
      if ((fq.size() < 10) && ($urandom % 2 == 0)) pushWord({$urandom, $urandom});
    end
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
